// File: rtl/spi2lb_pkg.sv
// Shared types and command codes for the SPI to local-bus bridge.
package spi2lb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_WDATA,
    S_WRITE,
    S_RWAIT,
    S_RDATA,
    S_SKIP
  } state_t;

  localparam logic [7:0] CMD_WR = 8'h02;
  localparam logic [7:0] CMD_RD = 8'h03;

endpackage

// File: rtl/spi2lb_sync.sv
// Two-flop synchronizer for one asynchronous SPI pin, plus a third flop for
// rise/fall detection on the synchronized level.
module spi2lb_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [2:0] s;

  // Resetting to 0 means a cs_n held low through reset never looks like a new frame start.
  always_ff @(posedge clk) begin
    if (rst) s <= '0;
    else     s <= {s[1:0], din};
  end

  assign q    = s[1];
  assign rise = s[1] & ~s[2];
  assign fall = ~s[1] & s[2];

endmodule

// File: rtl/spi2lb.sv
// SPI mode-0 slave to local-bus master bridge: one bus access per cs_n-low frame.
//   state   | meaning
//   S_IDLE  | waiting for cs_n fall
//   S_CMD   | shifting in command byte
//   S_ADDR  | shifting in address byte
//   S_WDATA | shifting in write data
//   S_WRITE | lb_wen held until lb_wready
//   S_RWAIT | dummy byte, waiting for lb_rvalid
//   S_RDATA | shifting read data out on miso
//   S_SKIP  | frame done or rejected, ignore sck until cs_n high
module spi2lb
  import spi2lb_pkg::*;
#(
  parameter int               ADDR_W = 8,
  parameter int               DATA_W = 16,
  parameter int               STRB_W = DATA_W / 8,
  parameter logic [DATA_W-1:0] RD_ERR = 16'hDEAD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sck,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] lb_waddr,
  output logic [DATA_W-1:0] lb_wdata,
  output logic              lb_wen,
  output logic [STRB_W-1:0] lb_wstrb,
  input  logic              lb_wready,
  output logic [ADDR_W-1:0] lb_raddr,
  output logic              lb_ren,
  input  logic [DATA_W-1:0] lb_rdata,
  input  logic              lb_rvalid,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LEN_BYTE = CNT_W'(7);
  localparam logic [CNT_W-1:0] LEN_DATA = CNT_W'(DATA_W - 1);

  state_t state, state_d;
  logic   err_d;

  logic sck_q, sck_rise, sck_fall;
  logic cs_q, cs_rise, cs_fall;
  logic mosi_q, mosi_rise, mosi_fall;
  logic unused_edges;

  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rx_sr, rx_next, tx_sr;
  logic [7:0]        rx_byte;
  logic              is_rd, got_rd, dummy_done, last_bit;

  spi2lb_sync u_sync_sck  (.clk(clk), .rst(rst), .din(spi_sck),  .q(sck_q),  .rise(sck_rise),  .fall(sck_fall));
  spi2lb_sync u_sync_cs   (.clk(clk), .rst(rst), .din(spi_cs_n), .q(cs_q),   .rise(cs_rise),   .fall(cs_fall));
  spi2lb_sync u_sync_mosi (.clk(clk), .rst(rst), .din(spi_mosi), .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall));

  assign unused_edges = ^{sck_q, cs_rise, mosi_rise, mosi_fall};

  assign rx_next  = {rx_sr[DATA_W-2:0], mosi_q};
  assign rx_byte  = rx_next[7:0];
  assign last_bit = sck_rise && (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    err_d   = 1'b0;
    // A pending write is allowed to finish even if cs_n has already gone high.
    if (state != S_IDLE && state != S_WRITE && cs_q) begin
      state_d = S_IDLE;
      err_d   = (state != S_SKIP);
    end else begin
      unique case (state)
        S_IDLE:  if (cs_fall) state_d = S_CMD;
        S_CMD:   if (last_bit) begin
                   if (rx_byte == CMD_WR || rx_byte == CMD_RD) begin
                     state_d = S_ADDR;
                   end else begin
                     state_d = S_SKIP;
                     err_d   = 1'b1;
                   end
                 end
        S_ADDR:  if (last_bit) state_d = is_rd ? S_RWAIT : S_WDATA;
        S_WDATA: if (last_bit) state_d = S_WRITE;
        S_WRITE: if (lb_wready) state_d = S_SKIP;
        S_RWAIT: if (sck_fall && dummy_done) begin
                   state_d = S_RDATA;
                   err_d   = !got_rd && !lb_rvalid;
                 end
        S_RDATA: if (last_bit) state_d = S_SKIP;
        S_SKIP:  state_d = S_SKIP;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      rx_sr      <= '0;
      tx_sr      <= '0;
      is_rd      <= 1'b0;
      got_rd     <= 1'b0;
      dummy_done <= 1'b0;
      lb_waddr   <= '0;
      lb_raddr   <= '0;
      lb_wdata   <= '0;
      lb_ren     <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      lb_ren    <= (state == S_ADDR) && (state_d == S_RWAIT);
      frame_err <= err_d;
      unique case (state)
        S_IDLE: begin
          cnt        <= LEN_BYTE;
          got_rd     <= 1'b0;
          dummy_done <= 1'b0;
        end
        S_CMD, S_ADDR, S_WDATA: begin
          if (sck_rise) begin
            rx_sr <= rx_next;
            cnt   <= cnt - CNT_W'(1);
          end
          if (last_bit) begin
            unique case (state)
              S_CMD: begin
                is_rd <= (rx_byte == CMD_RD);
                cnt   <= LEN_BYTE;
              end
              S_ADDR: begin
                lb_waddr <= ADDR_W'(rx_byte);
                lb_raddr <= ADDR_W'(rx_byte);
                cnt      <= is_rd ? LEN_BYTE : LEN_DATA;
              end
              default: begin
                lb_wdata <= rx_next;
                cnt      <= LEN_BYTE;
              end
            endcase
          end
        end
        S_RWAIT: begin
          if (!got_rd && lb_rvalid) begin
            tx_sr  <= lb_rdata;
            got_rd <= 1'b1;
          end else if (sck_fall && dummy_done && !got_rd) begin
            tx_sr <= RD_ERR;
          end
          if (sck_rise) begin
            if (cnt == '0) begin
              dummy_done <= 1'b1;
              cnt        <= LEN_BYTE;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          if (sck_fall && dummy_done) cnt <= LEN_DATA;
        end
        S_RDATA: begin
          if (sck_fall) tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
          if (sck_rise) cnt <= (cnt == '0) ? LEN_BYTE : cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign lb_wen   = (state == S_WRITE);
  assign lb_wstrb = {STRB_W{lb_wen}};
  assign spi_miso = (state == S_RDATA) && tx_sr[DATA_W-1];

endmodule

// File: tb/tb_spi2lb.sv
// Directed bench for spi2lb: SPI master bit-bang tasks plus a local-bus responder.
module tb_spi2lb;

  localparam int H = 6;  // clk cycles per sck half period

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spi_sck = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
  logic        spi_miso;
  logic [7:0]  lb_waddr, lb_raddr;
  logic [15:0] lb_wdata, lb_rdata = '0;
  logic        lb_wen, lb_ren, lb_rvalid = 1'b0, lb_wready = 1'b0, frame_err;
  logic [1:0]  lb_wstrb;

  int n_chk = 0, n_pass = 0;

  int rd_mode = 0;            // 0: rvalid one cycle after ren, 1: never
  logic [15:0] rd_data = '0;
  int wr_delay = 0;
  int ren_cnt = 0, wen_cycles = 0, err_cnt = 0, unstable = 0, bad_strb = 0;
  logic [7:0]  w_addr = '0;
  logic [15:0] w_data = '0;

  spi2lb dut (
    .clk(clk), .rst(rst),
    .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .lb_waddr(lb_waddr), .lb_wdata(lb_wdata), .lb_wen(lb_wen), .lb_wstrb(lb_wstrb),
    .lb_wready(lb_wready), .lb_raddr(lb_raddr), .lb_ren(lb_ren), .lb_rdata(lb_rdata),
    .lb_rvalid(lb_rvalid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Local-bus responder and activity monitor, sampled on negedges.
  initial begin
    int wen_seen = 0;
    bit rv_pend = 0;
    forever begin
      @(negedge clk);
      lb_rvalid = 1'b0;
      lb_rdata  = '0;
      if (rv_pend) begin
        lb_rvalid = 1'b1;
        lb_rdata  = rd_data;
        rv_pend   = 0;
      end
      if (lb_ren) begin
        ren_cnt++;
        if (rd_mode == 0) rv_pend = 1;
      end
      if (frame_err) err_cnt++;
      if (lb_wen) begin
        if (wen_seen == 0) begin
          w_addr = lb_waddr;
          w_data = lb_wdata;
        end else if (lb_waddr != w_addr || lb_wdata != w_data) begin
          unstable++;
        end
        if (lb_wstrb != 2'b11) bad_strb++;
        lb_wready = (wen_seen >= wr_delay);
        wen_seen++;
        wen_cycles++;
      end else begin
        lb_wready = 1'b0;
        wen_seen  = 0;
      end
    end
  end

  task automatic clear_counts();
    ren_cnt = 0; wen_cycles = 0; err_cnt = 0; unstable = 0; bad_strb = 0;
  endtask

  task automatic spi_bit(input logic b, output logic m);
    @(negedge clk);
    spi_mosi = b;
    repeat (H) @(negedge clk);
    m = spi_miso;
    spi_sck = 1'b1;
    repeat (H) @(negedge clk);
    spi_sck = 1'b0;
  endtask

  task automatic send_bits(input logic [63:0] bits, input int n, output logic [31:0] rx);
    logic m;
    rx = '0;
    for (int i = 0; i < n; i++) begin
      spi_bit(bits[n-1-i], m);
      rx = {rx[30:0], m};
    end
  endtask

  task automatic frame(input logic [63:0] bits, input int n, output logic [31:0] rx);
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (H) @(negedge clk);
    send_bits(bits, n, rx);
    repeat (H) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (30) @(negedge clk);
  endtask

  initial begin
    logic [31:0] rx;
    logic [63:0] b;

    repeat (4) @(negedge clk);
    chk("rst_wen", lb_wen, 0);
    chk("rst_ren", lb_ren, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_miso", spi_miso, 0);
    chk("rst_waddr", lb_waddr, 0);
    chk("rst_wdata", lb_wdata, 0);
    chk("rst_wstrb", lb_wstrb, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    clear_counts();

    // Plain write
    wr_delay = 0;
    b = 64'(32'h0204_8015);
    frame(b, 32, rx);
    chk("wr_wen_cycles", wen_cycles, 1);
    chk("wr_waddr", w_addr, 8'h04);
    chk("wr_wdata", w_data, 16'h8015);
    chk("wr_strb", bad_strb, 0);
    chk("wr_err", err_cnt, 0);
    chk("wr_ren", ren_cnt, 0);
    chk("wr_wen_low", lb_wen, 0);

    // Read with data returned
    clear_counts();
    rd_mode = 0; rd_data = 16'h0111;
    b = 64'(40'h03_00_00_0000);
    frame(b, 40, rx);
    chk("rd_data", rx[15:0], 16'h0111);
    chk("rd_dummy_miso", rx[23:16], 0);
    chk("rd_ren_cnt", ren_cnt, 1);
    chk("rd_raddr", lb_raddr, 8'h00);
    chk("rd_err", err_cnt, 0);
    chk("rd_wen", wen_cycles, 0);

    // Read timeout
    clear_counts();
    rd_mode = 1;
    b = 64'(40'h03_2A_00_0000);
    frame(b, 40, rx);
    chk("to_data", rx[15:0], 16'hDEAD);
    chk("to_err", err_cnt, 1);
    chk("to_ren_cnt", ren_cnt, 1);
    chk("to_raddr", lb_raddr, 8'h2A);

    // Write with slow wready
    clear_counts();
    wr_delay = 5;
    b = 64'(32'h0237_C3A5);
    frame(b, 32, rx);
    chk("slow_wen_cycles", wen_cycles, 6);
    chk("slow_stable", unstable, 0);
    chk("slow_waddr", w_addr, 8'h37);
    chk("slow_wdata", w_data, 16'hC3A5);
    chk("slow_err", err_cnt, 0);
    wr_delay = 0;

    // Bad command
    clear_counts();
    b = 64'(32'h5504_1234);
    frame(b, 32, rx);
    chk("badcmd_err", err_cnt, 1);
    chk("badcmd_wen", wen_cycles, 0);
    chk("badcmd_ren", ren_cnt, 0);

    // Aborted write after 12 bits
    clear_counts();
    b = 64'(12'h020);
    frame(b, 12, rx);
    chk("abort_err", err_cnt, 1);
    chk("abort_wen", wen_cycles, 0);
    chk("abort_ren", ren_cnt, 0);

    // Reset during RDATA, then a fresh read
    clear_counts();
    rd_mode = 0; rd_data = 16'hFFFF;
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (H) @(negedge clk);
    b = 64'(28'h03_10_00_0);
    send_bits(b, 28, rx);
    repeat (H) @(negedge clk);
    chk("mid_miso_before", spi_miso, 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_miso", spi_miso, 0);
    chk("mid_rst_ren", lb_ren, 0);
    chk("mid_rst_wen", lb_wen, 0);
    rst = 1'b0;
    clear_counts();
    b = 64'(16'hFFFF);
    send_bits(b, 16, rx);
    chk("mid_ignored_miso", rx[15:0], 0);
    repeat (H) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("mid_ignored_ren", ren_cnt, 0);
    chk("mid_ignored_err", err_cnt, 0);

    rd_data = 16'hA55A;
    b = 64'(40'h03_7E_00_0000);
    frame(b, 40, rx);
    chk("post_rst_data", rx[15:0], 16'hA55A);
    chk("post_rst_ren", ren_cnt, 1);
    chk("post_rst_raddr", lb_raddr, 8'h7E);
    chk("post_rst_err", err_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
